// File: rtl/genius_pkg.sv
// Shared types for the Genius round engine: FSM states, playback level codes
// and the saturating two-digit BCD increment used for the score.
package genius_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPEND,
        S_SHOW,
        S_WAIT,
        S_ROUND_END,
        S_LOSE,
        S_DONE
    } state_t;

    localparam logic [1:0] L_025 = 2'b00;
    localparam logic [1:0] L_05  = 2'b01;
    localparam logic [1:0] L_1   = 2'b10;
    localparam logic [1:0] L_2   = 2'b11;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/genius_tick_gen.sv
// Playback-rate and 1 Hz tick dividers. A single clear restarts both; the
// engine only ever looks at one of them at a time, so sharing it is safe.
module genius_tick_gen
    import genius_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    input  logic [1:0] i_level,
    output logic       o_rate_tick,
    output logic       o_sec_tick
);

    localparam int CW   = $clog2(CLK_HZ * 4);
    localparam int HALF = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;

    logic [CW-1:0] r_rate_cnt;
    logic [CW-1:0] r_sec_cnt;
    logic [CW-1:0] w_rate_top;

    always_comb begin
        case (i_level)
            L_025:   w_rate_top = CW'(CLK_HZ * 4 - 1);
            L_05:    w_rate_top = CW'(CLK_HZ * 2 - 1);
            L_1:     w_rate_top = CW'(CLK_HZ - 1);
            default: w_rate_top = CW'(HALF - 1);
        endcase
    end

    assign o_rate_tick = (r_rate_cnt == w_rate_top);
    assign o_sec_tick  = (r_sec_cnt == CW'(CLK_HZ - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rate_cnt <= '0;
            r_sec_cnt  <= '0;
        end else if (i_clr) begin
            r_rate_cnt <= '0;
            r_sec_cnt  <= '0;
        end else begin
            r_rate_cnt <= o_rate_tick ? '0 : r_rate_cnt + 1'b1;
            r_sec_cnt  <= o_sec_tick  ? '0 : r_sec_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/genius_round_engine.sv
// Genius (Simon) game core: grows a pseudo-random sequence each round, plays it
// on the LEDs, checks key presses against it and tracks timeout, round and score.
module genius_round_engine
    import genius_pkg::*;
#(
    parameter int          N_KEYS     = 4,
    parameter int          MAX_ROUNDS = 16,
    parameter int          CLK_HZ     = 50_000_000,
    parameter int          TIME_LIMIT = 5,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                              i_CLOCK_50,
    input  logic                              i_reset_n,
    input  logic                              i_start,
    input  logic [1:0]                        i_level,
    input  logic [$clog2(MAX_ROUNDS+1)-1:0]   i_setup_rounds,
    input  logic [N_KEYS-1:0]                 i_KEY,
    output logic [N_KEYS-1:0]                 o_leds,
    output logic [$clog2(MAX_ROUNDS+1)-1:0]   o_round,
    output logic [7:0]                        o_points_bcd,
    output logic [3:0]                        o_time_left,
    output logic                              o_end_FPGA,
    output logic                              o_end_User,
    output logic                              o_end_time,
    output logic                              o_win,
    output logic                              o_match
);

    localparam int RW = $clog2(MAX_ROUNDS + 1);
    localparam int IW = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;
    localparam int SW = $clog2(N_KEYS);

    state_t            r_state, w_nxt;
    logic [15:0]       r_lfsr;
    logic [SW-1:0]     r_mem [MAX_ROUNDS];
    logic [IW-1:0]     r_idx;
    logic [RW-1:0]     r_round, r_tgt;
    logic [1:0]        r_level;
    logic              r_phase;
    logic [N_KEYS-1:0] r_key_prev;
    logic [7:0]        r_points;
    logic [3:0]        r_time_left;
    logic              r_end_time, r_win, r_match;

    logic [SW-1:0]     w_sym;
    logic [N_KEYS-1:0] w_exp_onehot;
    logic [RW-1:0]     w_tgt;
    logic              w_press, w_correct, w_last, w_show_done, w_clr;
    logic              w_rate_tick, w_sec_tick;

    genius_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .i_clk       (i_CLOCK_50),
        .i_rst_n     (i_reset_n),
        .i_clr       (w_clr),
        .i_level     (r_level),
        .o_rate_tick (w_rate_tick),
        .o_sec_tick  (w_sec_tick)
    );

    assign w_sym        = SW'(r_lfsr[SW-1:0] % N_KEYS);
    assign w_exp_onehot = N_KEYS'(1) << r_mem[r_idx];
    assign w_tgt        = (i_setup_rounds == '0 || i_setup_rounds > RW'(MAX_ROUNDS))
                          ? RW'(MAX_ROUNDS) : i_setup_rounds;
    // Key history follows KEY every cycle, so a key already down when WAIT opens never counts.
    assign w_press      = |(i_KEY & ~r_key_prev);
    assign w_correct    = w_press && (i_KEY == w_exp_onehot);
    assign w_last       = (RW'(r_idx) == r_round - RW'(1));
    assign w_show_done  = (r_state == S_SHOW) && w_rate_tick && r_phase && w_last;
    assign w_clr        = (r_state == S_APPEND) || w_show_done ||
                          ((r_state == S_WAIT) && w_correct);

    always_ff @(posedge i_CLOCK_50 or negedge i_reset_n) begin
        if (!i_reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE, S_LOSE, S_DONE: if (i_start) w_nxt = S_APPEND;
            S_APPEND:               w_nxt = S_SHOW;
            S_SHOW:                 if (w_show_done) w_nxt = S_WAIT;
            S_WAIT: begin
                if (w_press)
                    w_nxt = !w_correct ? S_LOSE : (w_last ? S_ROUND_END : S_WAIT);
                else if (w_sec_tick && r_time_left == 4'd1)
                    w_nxt = S_LOSE;
            end
            S_ROUND_END:            w_nxt = (r_round == r_tgt) ? S_DONE : S_APPEND;
            default:                w_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_leds     = '0;
        o_end_FPGA = 1'b0;
        o_end_User = 1'b0;
        case (r_state)
            S_SHOW:      if (!r_phase) o_leds = w_exp_onehot;
            S_WAIT:      o_end_FPGA = 1'b1;
            S_ROUND_END: o_end_User = 1'b1;
            default:     ;
        endcase
    end

    always_ff @(posedge i_CLOCK_50 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_lfsr      <= LFSR_SEED;
            for (int i = 0; i < MAX_ROUNDS; i++) r_mem[i] <= '0;
            r_idx       <= '0;
            r_round     <= '0;
            r_tgt       <= '0;
            r_level     <= '0;
            r_phase     <= 1'b0;
            r_key_prev  <= '0;
            r_points    <= '0;
            r_time_left <= '0;
            r_end_time  <= 1'b0;
            r_win       <= 1'b0;
            r_match     <= 1'b0;
        end else begin
            // Free-running so the moment of start seeds the sequence.
            r_lfsr     <= r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
            r_key_prev <= i_KEY;
            r_match    <= 1'b0;
            case (r_state)
                S_IDLE, S_LOSE, S_DONE: begin
                    if (i_start) begin
                        r_level     <= i_level;
                        r_tgt       <= w_tgt;
                        r_points    <= '0;
                        r_end_time  <= 1'b0;
                        r_win       <= 1'b0;
                        r_time_left <= '0;
                        r_round     <= RW'(1);
                    end
                end
                S_APPEND: begin
                    r_mem[IW'(r_round - RW'(1))] <= w_sym;
                    r_idx   <= '0;
                    r_phase <= 1'b0;
                end
                S_SHOW: begin
                    if (w_rate_tick) begin
                        r_phase <= ~r_phase;
                        if (r_phase) begin
                            if (w_last) begin
                                r_idx       <= '0;
                                r_time_left <= 4'(TIME_LIMIT);
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    // A press in the same cycle as the last second tick takes priority.
                    if (w_press) begin
                        if (w_correct) begin
                            r_match     <= 1'b1;
                            r_points    <= bcd_inc(r_points);
                            r_time_left <= 4'(TIME_LIMIT);
                            if (!w_last) r_idx <= r_idx + 1'b1;
                        end
                    end else if (w_sec_tick) begin
                        if (r_time_left == 4'd1) begin
                            r_time_left <= '0;
                            r_end_time  <= 1'b1;
                        end else begin
                            r_time_left <= r_time_left - 4'd1;
                        end
                    end
                end
                S_ROUND_END: begin
                    if (r_round == r_tgt)
                        r_win <= 1'b1;
                    else
                        r_round <= r_round + RW'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_round      = r_round;
    assign o_points_bcd = r_points;
    assign o_time_left  = r_time_left;
    assign o_end_time   = r_end_time;
    assign o_win        = r_win;
    assign o_match      = r_match;

endmodule
